alu_issue_ctrl: RTL and testbench

//  Multi-cycle issue/writeback stage that sits upstream of the 2-bit-opcode ALU.

---
 rtl/alu_issue_ctrl.sv | 141 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback stage in front of a 2-bit-opcode ALU: owns the register file,
// sequences READ -> EXEC -> WB per instruction and exposes load and debug ports.
module alu_issue_ctrl #(
   parameter int DATA_W     = 8,
   parameter int REG_ADDR_W = 2,
   localparam int NUM_REGS  = 2**REG_ADDR_W,
   localparam int INSTR_W   = 2 + 3*REG_ADDR_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  instr_valid,
   input  logic [INSTR_W-1:0]    instr,
   output logic                  instr_ready,
   input  logic                  ld_en,
   input  logic [REG_ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0]     ld_data,
   output logic [DATA_W-1:0]     alu_a,
   output logic [DATA_W-1:0]     alu_b,
   output logic [1:0]            alu_op,
   input  logic [DATA_W-1:0]     alu_result,
   output logic                  wb_valid,
   output logic [REG_ADDR_W-1:0] wb_addr,
   output logic [DATA_W-1:0]     wb_data,
   output logic                  zero_flag,
   output logic                  busy,
   input  logic [REG_ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0]     dbg_data
);

   typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

   state_t                  state_q, state_d;
   logic [INSTR_W-1:0]      instr_q, instr_d;
   logic [DATA_W-1:0]       regs_q [NUM_REGS];
   logic [DATA_W-1:0]       regs_d [NUM_REGS];
   logic [DATA_W-1:0]       alu_a_q, alu_a_d;
   logic [DATA_W-1:0]       alu_b_q, alu_b_d;
   logic [1:0]              alu_op_q, alu_op_d;
   logic [DATA_W-1:0]       res_q, res_d;
   logic                    wb_valid_q, wb_valid_d;
   logic [REG_ADDR_W-1:0]   wb_addr_q, wb_addr_d;
   logic [DATA_W-1:0]       wb_data_q, wb_data_d;
   logic                    zero_q, zero_d;

   logic [1:0]              opc;
   logic [REG_ADDR_W-1:0]   rd, rs1, rs2;

   assign opc = instr_q[INSTR_W-1 -: 2];
   assign rd  = instr_q[3*REG_ADDR_W-1 -: REG_ADDR_W];
   assign rs1 = instr_q[2*REG_ADDR_W-1 -: REG_ADDR_W];
   assign rs2 = instr_q[REG_ADDR_W-1:0];

   always_comb begin
      state_d    = state_q;
      instr_d    = instr_q;
      regs_d     = regs_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      alu_op_d   = alu_op_q;
      res_d      = res_q;
      wb_valid_d = 1'b0;
      wb_addr_d  = wb_addr_q;
      wb_data_d  = wb_data_q;
      zero_d     = zero_q;

      // The load is applied first so a writeback to the same register overrides it.
      if (ld_en) begin
         regs_d[ld_addr] = ld_data;
      end

      case (state_q)
         IDLE: begin
            if (instr_valid) begin
               instr_d = instr;
               state_d = READ;
            end
         end
         READ: begin
            alu_a_d  = regs_q[rs1];
            alu_b_d  = regs_q[rs2];
            alu_op_d = opc;
            state_d  = EXEC;
         end
         EXEC: begin
            res_d   = alu_result;
            state_d = WB;
         end
         WB: begin
            regs_d[rd] = res_q;
            wb_valid_d = 1'b1;
            wb_addr_d  = rd;
            wb_data_d  = res_q;
            zero_d     = (res_q == '0);
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         instr_q    <= '0;
         regs_q     <= '{default: '0};
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_op_q   <= 2'b00;
         res_q      <= '0;
         wb_valid_q <= 1'b0;
         wb_addr_q  <= '0;
         wb_data_q  <= '0;
         zero_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         instr_q    <= instr_d;
         regs_q     <= regs_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         alu_op_q   <= alu_op_d;
         res_q      <= res_d;
         wb_valid_q <= wb_valid_d;
         wb_addr_q  <= wb_addr_d;
         wb_data_q  <= wb_data_d;
         zero_q     <= zero_d;
      end
   end

   assign instr_ready = (state_q == IDLE);
   assign busy        = (state_q != IDLE);
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_op      = alu_op_q;
   assign wb_valid    = wb_valid_q;
   assign wb_addr     = wb_addr_q;
   assign wb_data     = wb_data_q;
   assign zero_flag   = zero_q;
   assign dbg_data    = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: a reference ALU drives alu_result, and a
// scoreboard queue of expected writebacks is filled at accept and drained by a monitor.
module tb_alu_issue_ctrl;

   localparam int DW = 8;
   localparam int AW = 2;
   localparam int IW = 2 + 3*AW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          instr_valid;
   logic [IW-1:0] instr;
   logic          instr_ready;
   logic          ld_en;
   logic [AW-1:0] ld_addr;
   logic [DW-1:0] ld_data;
   logic [DW-1:0] alu_a, alu_b;
   logic [1:0]    alu_op;
   logic [DW-1:0] alu_result;
   logic          wb_valid;
   logic [AW-1:0] wb_addr;
   logic [DW-1:0] wb_data;
   logic          zero_flag;
   logic          busy;
   logic [AW-1:0] dbg_addr;
   logic [DW-1:0] dbg_data;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wb_exp_t;

   wb_exp_t       exp_q [$];
   logic [DW-1:0] model_r [4];
   int            checks   = 0;
   int            failures = 0;
   int            cyc      = 0;
   int            wb_count = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   alu_issue_ctrl #(.DATA_W(DW), .REG_ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .zero_flag(zero_flag), .busy(busy),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   function automatic logic [DW-1:0] alu_f(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
      case (op)
         2'b00:   return a + b;
         2'b01:   return a - b;
         2'b10:   return a & b;
         default: return a | b;
      endcase
   endfunction

   always_comb alu_result = alu_f(alu_op, alu_a, alu_b);

   // Scoreboard drain: every writeback pulse must match the oldest expected entry.
   always @(negedge clk) begin
      if (rst_n && wb_valid) begin
         wb_count++;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL wb_unexpected: got addr=%0d data=%02h, required no writeback", wb_addr, wb_data);
         end else begin
            wb_exp_t e;
            e = exp_q.pop_front();
            if (wb_addr !== e.addr || wb_data !== e.data) begin
               failures++;
               $display("[TB] FAIL wb_scoreboard: got addr=%0d data=%02h, required addr=%0d data=%02h",
                        wb_addr, wb_data, e.addr, e.data);
            end
         end
      end
   end

   task automatic do_reset();
      rst_n       = 1'b0;
      instr_valid = 1'b0;
      instr       = '0;
      ld_en       = 1'b0;
      ld_addr     = '0;
      ld_data     = '0;
      dbg_addr    = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) model_r[i] = '0;
      exp_q.delete();
   endtask

   task automatic load_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
      ld_en   = 1'b1;
      ld_addr = a;
      ld_data = d;
      @(negedge clk);
      ld_en      = 1'b0;
      model_r[a] = d;
   endtask

   // Offers an instruction and returns at the negedge after the accepting edge.
   task automatic issue(input logic [1:0] opc, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                        input logic [AW-1:0] rs2, output int acc_edge, output int stalls);
      wb_exp_t e;
      bit      ok = 1'b0;
      instr_valid = 1'b1;
      instr       = {opc, rd, rs1, rs2};
      stalls      = 0;
      acc_edge    = -1;
      for (int i = 0; i < 20; i++) begin
         if (instr_ready) begin
            ok = 1'b1;
            break;
         end
         stalls++;
         @(negedge clk);
      end
      if (ok) begin
         @(negedge clk);
         acc_edge    = cyc;
         instr_valid = 1'b0;
         e.addr      = rd;
         e.data      = alu_f(opc, model_r[rs1], model_r[rs2]);
         exp_q.push_back(e);
         model_r[rd] = e.data;
      end else begin
         checks++;
         failures++;
         instr_valid = 1'b0;
         $display("[TB] FAIL accept_timeout: got instr_ready=0 for 20 cycles, required acceptance");
      end
   endtask

   task automatic wait_wb(output int wb_edge);
      wb_edge = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (wb_valid) begin
            wb_edge = cyc;
            break;
         end
      end
      if (wb_edge < 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL wb_timeout: got no wb_valid in 20 cycles, required a pulse");
      end
   endtask

   task automatic test_reset();
      int acc, st, wbc;
      checks++; if (busy !== 1'b0)        begin failures++; $display("[TB] FAIL rst_busy: got %b required 0", busy); end
      checks++; if (instr_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_ready: got %b required 1", instr_ready); end
      checks++; if (wb_valid !== 1'b0)    begin failures++; $display("[TB] FAIL rst_wb_valid: got %b required 0", wb_valid); end
      checks++; if (zero_flag !== 1'b0)   begin failures++; $display("[TB] FAIL rst_zero: got %b required 0", zero_flag); end
      checks++; if (alu_op !== 2'b00 || alu_a !== 8'h00 || alu_b !== 8'h00)
         begin failures++; $display("[TB] FAIL rst_alu: got op=%b a=%02h b=%02h required 0/00/00", alu_op, alu_a, alu_b); end
      checks++; if (wb_addr !== 2'd0 || wb_data !== 8'h00)
         begin failures++; $display("[TB] FAIL rst_wb: got addr=%0d data=%02h required 0/00", wb_addr, wb_data); end

      // Abandon an instruction by resetting while it sits in EXEC.
      load_reg(2'd1, 8'h05);
      load_reg(2'd2, 8'h06);
      issue(2'b00, 2'd3, 2'd1, 2'd2, acc, st);
      @(negedge clk);
      checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL exec_busy: got %b required 1", busy); end
      wbc   = wb_count;
      rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || instr_ready !== 1'b1)
         begin failures++; $display("[TB] FAIL midrst_state: got busy=%b ready=%b required 0/1", busy, instr_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) model_r[i] = '0;
      exp_q.delete();
      repeat (6) @(negedge clk);
      checks++; if (wb_count !== wbc) begin failures++; $display("[TB] FAIL midrst_no_wb: got %0d pulses required 0", wb_count - wbc); end
      checks++; if (zero_flag !== 1'b0) begin failures++; $display("[TB] FAIL midrst_zero: got %b required 0", zero_flag); end
      for (int i = 0; i < 4; i++) begin
         dbg_addr = AW'(i);
         #1;
         checks++;
         if (dbg_data !== 8'h00) begin failures++; $display("[TB] FAIL midrst_reg%0d: got %02h required 00", i, dbg_data); end
      end
   endtask

   task automatic test_add_wrap();
      int acc, st, we;
      load_reg(2'd1, 8'hF0);
      load_reg(2'd2, 8'h20);
      issue(2'b00, 2'd3, 2'd1, 2'd2, acc, st);
      wait_wb(we);
      checks++; if (we - acc != 3) begin failures++; $display("[TB] FAIL add_latency: got %0d edges required 3", we - acc); end
      checks++; if (zero_flag !== 1'b0) begin failures++; $display("[TB] FAIL add_zero: got %b required 0", zero_flag); end
      dbg_addr = 2'd3;
      #1;
      checks++; if (dbg_data !== 8'h10) begin failures++; $display("[TB] FAIL add_r3: got %02h required 10", dbg_data); end
   endtask

   task automatic test_sub_zero();
      int acc, st, we;
      load_reg(2'd1, 8'h55);
      load_reg(2'd2, 8'h55);
      issue(2'b01, 2'd0, 2'd1, 2'd2, acc, st);
      wait_wb(we);
      checks++; if (zero_flag !== 1'b1) begin failures++; $display("[TB] FAIL sub_zero_flag: got %b required 1", zero_flag); end
      dbg_addr = 2'd0;
      #1;
      checks++; if (dbg_data !== 8'h00) begin failures++; $display("[TB] FAIL sub_r0: got %02h required 00", dbg_data); end
      load_reg(2'd1, 8'h00);
      load_reg(2'd2, 8'h01);
      checks++; if (zero_flag !== 1'b1) begin failures++; $display("[TB] FAIL ld_keeps_zero: got %b required 1", zero_flag); end
      issue(2'b01, 2'd3, 2'd1, 2'd2, acc, st);
      wait_wb(we);
      checks++; if (zero_flag !== 1'b0) begin failures++; $display("[TB] FAIL sub_wrap_zero: got %b required 0", zero_flag); end
      dbg_addr = 2'd3;
      #1;
      checks++; if (dbg_data !== 8'hFF) begin failures++; $display("[TB] FAIL sub_wrap_r3: got %02h required FF", dbg_data); end
   endtask

   task automatic test_back_to_back();
      int a1, a2, s1, s2, we;
      load_reg(2'd1, 8'hCC);
      load_reg(2'd2, 8'hAA);
      issue(2'b10, 2'd3, 2'd1, 2'd2, a1, s1);
      issue(2'b11, 2'd0, 2'd3, 2'd2, a2, s2);
      checks++; if (a2 - a1 != 4) begin failures++; $display("[TB] FAIL b2b_spacing: got %0d edges required 4", a2 - a1); end
      wait_wb(we);
      checks++; if (we - a2 != 3) begin failures++; $display("[TB] FAIL b2b_latency: got %0d edges required 3", we - a2); end
      dbg_addr = 2'd3;
      #1;
      checks++; if (dbg_data !== 8'h88) begin failures++; $display("[TB] FAIL and_r3: got %02h required 88", dbg_data); end
      dbg_addr = 2'd0;
      #1;
      checks++; if (dbg_data !== 8'hAA) begin failures++; $display("[TB] FAIL or_r0: got %02h required AA", dbg_data); end
   endtask

   task automatic test_backpressure();
      int a1, a2, s1, s2, we, wbc;
      // R1=CC R2=AA R3=88 R0=AA from the previous scenario.
      issue(2'b00, 2'd1, 2'd1, 2'd2, a1, s1);
      wbc = wb_count;
      issue(2'b11, 2'd2, 2'd1, 2'd3, a2, s2);
      checks++; if (s2 != 3) begin failures++; $display("[TB] FAIL bp_stalls: got %0d required 3", s2); end
      checks++; if (a2 - a1 != 4) begin failures++; $display("[TB] FAIL bp_spacing: got %0d edges required 4", a2 - a1); end
      wait_wb(we);
      repeat (6) @(negedge clk);
      checks++; if (wb_count - wbc != 2) begin failures++; $display("[TB] FAIL bp_pulses: got %0d required 2", wb_count - wbc); end
      dbg_addr = 2'd2;
      #1;
      checks++; if (dbg_data !== 8'hFE) begin failures++; $display("[TB] FAIL bp_r2: got %02h required FE", dbg_data); end
   endtask

   task automatic test_ld_collision();
      int acc, st, we;
      // Load during READ to a source register: READ still sees the old value.
      issue(2'b00, 2'd3, 2'd0, 2'd1, acc, st);
      ld_en = 1'b1; ld_addr = 2'd0; ld_data = 8'h01;
      @(negedge clk);
      ld_en = 1'b0;
      model_r[0] = 8'h01;
      wait_wb(we);
      dbg_addr = 2'd3;
      #1;
      checks++; if (dbg_data !== 8'h20) begin failures++; $display("[TB] FAIL read_old_r3: got %02h required 20", dbg_data); end
      dbg_addr = 2'd0;
      #1;
      checks++; if (dbg_data !== 8'h01) begin failures++; $display("[TB] FAIL read_ld_r0: got %02h required 01", dbg_data); end

      // Load to the writeback target in the WB cycle: writeback wins.
      issue(2'b01, 2'd2, 2'd3, 2'd0, acc, st);
      repeat (2) @(negedge clk);
      ld_en = 1'b1; ld_addr = 2'd2; ld_data = 8'h77;
      @(negedge clk);
      ld_en = 1'b0;
      checks++; if (wb_valid !== 1'b1) begin failures++; $display("[TB] FAIL coll_wb_valid: got %b required 1", wb_valid); end
      dbg_addr = 2'd2;
      #1;
      checks++; if (dbg_data !== 8'h1F) begin failures++; $display("[TB] FAIL coll_same_r2: got %02h required 1F", dbg_data); end

      // Load to a different register in the WB cycle: both land.
      @(negedge clk);
      issue(2'b10, 2'd1, 2'd2, 2'd3, acc, st);
      repeat (2) @(negedge clk);
      ld_en = 1'b1; ld_addr = 2'd0; ld_data = 8'h5A;
      @(negedge clk);
      ld_en = 1'b0;
      model_r[0] = 8'h5A;
      dbg_addr = 2'd1;
      #1;
      checks++; if (dbg_data !== 8'h00) begin failures++; $display("[TB] FAIL coll_diff_r1: got %02h required 00", dbg_data); end
      dbg_addr = 2'd0;
      #1;
      checks++; if (dbg_data !== 8'h5A) begin failures++; $display("[TB] FAIL coll_diff_r0: got %02h required 5A", dbg_data); end
      checks++; if (zero_flag !== 1'b1) begin failures++; $display("[TB] FAIL coll_zero: got %b required 1", zero_flag); end
   endtask

   initial begin
      do_reset();
      test_reset();
      test_add_wrap();
      test_sub_zero();
      test_back_to_back();
      test_backpressure();
      test_ld_collision();
      repeat (4) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
